grid_read_arbiter: RTL and testbench
====================================

Name: grid_read_arbiter

Overview:
- Shares the single read port of the map grid memory among several requesters: the player updater, the raycaster and the enemy updater.
- Each requester presents a grid cell (x, y) and receives that cell's type code.
- Arbitration is round-robin, and every access completes with a fixed, known latency.
- Coordinates outside the map return a wall code without touching memory, so collision logic treats the map edge as solid.

Parameters:
- NUM_REQ, 3, number of requesters; index 0 = player updater, 1 = raycaster, 2 = enemy updater.
- X_W, 6, grid x coordinate width.
- Y_W, 5, grid y coordinate width.
- CELL_W, 3, cell type code width; 0 = empty.
- MAP_W, 40, number of valid x cells (0..MAP_W-1).
- MAP_H, 30, number of valid y cells (0..MAP_H-1).
- READ_LATENCY, 1, grid memory read latency in cycles (>=1).
- OOB_CELL, 3'b001, code returned for out-of-range coordinates.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level.
- req_x  in  NUM_REQ*X_W  flattened x coordinates; requester i uses bits [i*X_W +: X_W].
- req_y  in  NUM_REQ*Y_W  flattened y coordinates; requester i uses bits [i*Y_W +: Y_W].
- gnt  out  NUM_REQ  one-hot grant pulse, one cycle.
- rsp_valid  out  NUM_REQ  one-hot response pulse, one cycle.
- rsp_data  out  CELL_W  cell code shared by all requesters; valid while any rsp_valid bit is high.
- busy  out  1  high in every state except IDLE.
- mem_x  out  X_W  grid memory x address (registered).
- mem_y  out  Y_W  grid memory y address (registered).
- mem_rd  out  1  grid memory read strobe, one cycle.
- mem_data  in  CELL_W  grid memory read data; valid READ_LATENCY cycles after the mem_rd cycle.

Behaviour:
- Reset: all outputs are 0, state = IDLE, rr_ptr = 0, latency counter = 0. Reset mid-transaction drops the in-flight access; no rsp_valid is issued for it.

States and transitions:
- IDLE -> ISSUE when any req bit is high; otherwise stay in IDLE.
- ISSUE -> WAIT, one cycle.
- WAIT: stays READ_LATENCY-1 cycles (zero cycles when READ_LATENCY = 1), then -> CAPTURE.
- CAPTURE -> RESP, one cycle.
- RESP -> IDLE, one cycle.

IDLE (arbitration):
- Selects the first requesting index found scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
- Latches that index as sel and its coordinates into cur_x and cur_y.
- Computes oob = (x >= MAP_W) or (y >= MAP_H).

ISSUE cycle:
- gnt[sel] = 1.
- mem_x = cur_x and mem_y = cur_y.
- mem_rd = 1 only if oob is 0.

CAPTURE cycle (READ_LATENCY cycles after ISSUE):
- Samples mem_data, or OOB_CELL when oob is 1, into rsp_data.

RESP cycle:
- rsp_valid[sel] = 1; rsp_data holds its value until the next CAPTURE.
- rr_ptr becomes sel+1, or 0 when sel = NUM_REQ-1.

Timing:
- Total latency from a req seen in IDLE to rsp_valid is READ_LATENCY+2 cycles after ISSUE.
- Back-to-back throughput is one access per READ_LATENCY+3 cycles.
- Out-of-range accesses take the same latency as in-range accesses.

Requester contract:
- Hold req and coordinates until gnt. Coordinates are latched at arbitration, so later changes are ignored.
- Deassert req in the RESP cycle, or earlier, unless another access is wanted. The IDLE cycle following RESP re-arbitrates normally.
- If req is withdrawn after arbitration, the transaction still completes and rsp_valid still pulses.
- If req is withdrawn before arbitration, no grant is issued.

Simultaneous requests:
- Exactly one grant per transaction. The rotating priority guarantees every persistent requester is served within NUM_REQ transactions.

Invariants:
- gnt and rsp_valid are each one-hot or zero.
- mem_rd is never high outside ISSUE.

Test Plan:
- Single request: req[0] with x=5, y=3, memory cell = 3'b010, READ_LATENCY=1. Required: gnt[0] 1 cycle after req; mem_rd with mem_x=5, mem_y=3; rsp_valid[0] 3 cycles after gnt with rsp_data=2; busy low afterwards.
- Contention: req=3'b111 held continuously from reset. Required: grants in order 0,1,2,0, spaced 4 cycles apart; each rsp_data matches the cell of that requester's coordinates.
- Rotation: after a grant to 1, raise req=3'b011. Required: next grant goes to 0, not 1. A following grant with req=3'b110 goes to 1.
- Out of range: req[2] with x=45, y=10. Required: mem_rd stays 0; rsp_valid[2] arrives with rsp_data=3'b001 at normal latency. Also check x=39, y=29, which must perform a real read.
- Reset mid-operation: assert reset in the WAIT state. Required: no rsp_valid; all outputs 0 on the next cycle. A new req[1] is then granted first, since rr_ptr=0 and only 1 is requesting.
- READ_LATENCY=3 build: rsp_data equals mem_data presented exactly 3 cycles after mem_rd, and rsp_valid arrives 5 cycles after gnt. Corrupting mem_data on other cycles must not affect rsp_data.

Source files
------------

// File: rtl/grid_read_arbiter.sv
// Round-robin arbiter sharing the map grid memory read port between the player,
// raycaster and enemy updaters; out-of-map cells read back as a wall code.
module grid_read_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int X_W = 6,
  parameter int Y_W = 5,
  parameter int CELL_W = 3,
  parameter int MAP_W = 40,
  parameter int MAP_H = 30,
  parameter int READ_LATENCY = 1,
  parameter logic [CELL_W-1:0] OOB_CELL = 3'b001
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*X_W-1:0] req_x,
  input  logic [NUM_REQ*Y_W-1:0] req_y,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [CELL_W-1:0]      rsp_data,
  output logic                   busy,
  output logic [X_W-1:0]         mem_x,
  output logic [Y_W-1:0]         mem_y,
  output logic                   mem_rd,
  input  logic [CELL_W-1:0]      mem_data,
  output logic [2:0]             dbg_state
);
  // Handshake: req is a level held until the one-cycle gnt pulse; the matching
  // one-cycle rsp_valid pulse follows READ_LATENCY+2 cycles after gnt, and
  // rsp_data stays stable from that pulse until the next capture.

  localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int LAT_W = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               oob_q, oob_d;
  logic [SEL_W-1:0]   rr_q, rr_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [CELL_W-1:0]  rsp_data_q, rsp_data_d;
  logic               busy_q, busy_d;
  logic [X_W-1:0]     mem_x_q, mem_x_d;
  logic [Y_W-1:0]     mem_y_q, mem_y_d;
  logic               mem_rd_q, mem_rd_d;

  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;
  logic [X_W-1:0]     pick_x;
  logic [Y_W-1:0]     pick_y;
  logic               pick_oob;

  // First requester at or after rr_q, wrapping; its coordinates and range test.
  always_comb begin
    int idx;
    idx = 0;
    pick_found = 1'b0;
    pick_idx = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      idx = (int'(rr_q) + j) % NUM_REQ;
      if (!pick_found && req[idx]) begin
        pick_found = 1'b1;
        pick_idx = SEL_W'(idx);
      end
    end
    pick_x = req_x[int'(pick_idx)*X_W +: X_W];
    pick_y = req_y[int'(pick_idx)*Y_W +: Y_W];
    pick_oob = (int'(pick_x) >= MAP_W) || (int'(pick_y) >= MAP_H);
  end

  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    oob_d = oob_q;
    rr_d = rr_q;
    lat_d = lat_q;
    gnt_d = '0;
    rsp_valid_d = '0;
    rsp_data_d = rsp_data_q;
    mem_x_d = mem_x_q;
    mem_y_d = mem_y_q;
    mem_rd_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d = S_ISSUE;
          sel_d = pick_idx;
          oob_d = pick_oob;
          gnt_d = NUM_REQ'(1) << pick_idx;
          mem_x_d = pick_x;
          mem_y_d = pick_y;
          mem_rd_d = !pick_oob;
        end
      end
      S_ISSUE: begin
        lat_d = '0;
        state_d = (READ_LATENCY == 1) ? S_CAPTURE : S_WAIT;
      end
      S_WAIT: begin
        // Counts the READ_LATENCY-1 cycles between the strobe and the data.
        if (int'(lat_q) >= READ_LATENCY - 2) state_d = S_CAPTURE;
        else lat_d = lat_q + LAT_W'(1);
      end
      S_CAPTURE: begin
        rsp_data_d = oob_q ? OOB_CELL : mem_data;
        state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid_d = NUM_REQ'(1) << sel_q;
        rr_d = (int'(sel_q) == NUM_REQ - 1) ? '0 : sel_q + SEL_W'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      sel_q <= '0;
      oob_q <= 1'b0;
      rr_q <= '0;
      lat_q <= '0;
      gnt_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q <= '0;
      busy_q <= 1'b0;
      mem_x_q <= '0;
      mem_y_q <= '0;
      mem_rd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      oob_q <= oob_d;
      rr_q <= rr_d;
      lat_q <= lat_d;
      gnt_q <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q <= rsp_data_d;
      busy_q <= busy_d;
      mem_x_q <= mem_x_d;
      mem_y_q <= mem_y_d;
      mem_rd_q <= mem_rd_d;
    end
  end

  assign gnt = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data = rsp_data_q;
  assign busy = busy_q;
  assign mem_x = mem_x_q;
  assign mem_y = mem_y_q;
  assign mem_rd = mem_rd_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_grid_read_arbiter.sv
// Random-stimulus bench for grid_read_arbiter: one instance at READ_LATENCY=1 and
// one at 3, each with a memory model, a reference model and a response scoreboard.
module tb_grid_read_arbiter;

  logic clock;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  logic [2:0] cell_map [40][30];

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    for (int x = 0; x < 40; x++)
      for (int y = 0; y < 30; y++) cell_map[x][y] = 3'($urandom);
    cell_map[5][3] = 3'b010;
  end

  task automatic chk(input string name, input int k, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s dut%0d cycle=%0d actual=%0d expected=%0d", name, k, cyc, act, exp);
    end
  endtask

  function automatic logic [2:0] cell_of(input logic [5:0] x, input logic [4:0] y);
    if (x < 6'd40 && y < 5'd30) return cell_map[x][y];
    return 3'd0;
  endfunction

  // Coordinates biased toward the map edges and the named test cells.
  function automatic logic [10:0] pick_xy();
    logic [10:0] v;
    case ($urandom_range(0, 7))
      0: v = {6'd39, 5'd29};
      1: v = {6'd40, 5'($urandom_range(0, 29))};
      2: v = {6'($urandom_range(0, 39)), 5'd30};
      3: v = {6'd45, 5'd10};
      4: v = {6'd5, 5'd3};
      default: v = {6'($urandom), 5'($urandom)};
    endcase
    return v;
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_dut
    localparam int RL = (k == 0) ? 1 : 3;

    logic rst;
    logic [2:0] req;
    logic [17:0] rx;
    logic [14:0] ry;
    logic [2:0] gnt, rsp_valid, rsp_data, mem_data, dbg_state;
    logic busy, mem_rd;
    logic [5:0] mem_x;
    logic [4:0] mem_y;
    logic [36:0] exp_q[$];  // {index, cell, due cycle}
    int ph = 0;

    grid_read_arbiter #(.READ_LATENCY(RL)) u_dut (
      .clock(clock), .reset(rst), .req(req), .req_x(rx), .req_y(ry),
      .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
      .mem_x(mem_x), .mem_y(mem_y), .mem_rd(mem_rd), .mem_data(mem_data),
      .dbg_state(dbg_state)
    );

    // Driver, memory model and reference model; runs mid-low-phase each cycle.
    initial begin
      int ew, rr, free_c, last_iss, rcnt, rd_due;
      bit ob, rd_pend;
      logic [5:0] cx, rdx;
      logic [4:0] cy, rdy;
      logic [10:0] xy;
      rst = 1'b1; req = '0; rx = '0; ry = '0; mem_data = '0;
      rr = 0; free_c = 0; last_iss = -100; rcnt = 0; rd_due = 0; rd_pend = 0;
      forever begin
        @(negedge clock);
        if (rd_pend && rd_due == cyc) begin
          mem_data = cell_of(rdx, rdy);
          rd_pend = 0;
        end else begin
          mem_data = 3'($urandom);
        end
        if (mem_rd) begin
          rd_pend = 1; rd_due = cyc + RL; rdx = mem_x; rdy = mem_y;
        end

        ew = -1; ob = 0;
        if (rst) begin
          chk("reset_outputs", k, int'({gnt, rsp_data, busy, mem_rd, mem_x, mem_y, dbg_state}), 0);
          rr = 0; free_c = cyc; last_iss = -100; rd_pend = 0;
          exp_q.delete();
        end else begin
          if (cyc - 1 >= free_c && req != 3'b000) begin
            for (int j = 0; j < 3; j++)
              if (ew < 0 && req[(rr + j) % 3]) ew = (rr + j) % 3;
            cx = rx[ew*6 +: 6];
            cy = ry[ew*5 +: 5];
            ob = (cx >= 6'd40) || (cy >= 5'd30);
            exp_q.push_back({2'(ew), ob ? 3'b001 : cell_of(cx, cy), 32'(cyc + RL + 2)});
            free_c = cyc + RL + 2;
            last_iss = cyc;
            rr = (ew + 1) % 3;
          end
          chk("gnt", k, int'(gnt), (ew < 0) ? 0 : (1 << ew));
          chk("mem_rd", k, int'(mem_rd), (ew >= 0 && !ob) ? 1 : 0);
          if (ew >= 0 && !ob) begin
            chk("mem_x", k, int'(mem_x), int'(cx));
            chk("mem_y", k, int'(mem_y), int'(cy));
          end
          chk("busy", k, int'(busy), (cyc >= last_iss && cyc <= last_iss + RL + 1) ? 1 : 0);
        end

        if (cyc == 3) rst = 1'b0;
        if (cyc < 40) begin
          req = 3'b111;
          rx = {6'd45, 6'd39, 6'd5};
          ry = {5'd10, 5'd29, 5'd3};
        end else if (ph == 0 && cyc >= 1500 && ew < 0 && cyc == last_iss + 1) begin
          rst = 1'b1; req = '0; ph = 1; rcnt = 0;
        end else if (ph == 1) begin
          rcnt++;
          if (rcnt == 2) begin
            rst = 1'b0; req = 3'b010; rx[6 +: 6] = 6'd7; ry[5 +: 5] = 5'd8; ph = 2;
          end
        end else if (ph == 2) begin
          if (ew >= 0) begin
            req = '0; ph = 3;
          end
        end else if (cyc >= 2600) begin
          req = '0;
        end else begin
          for (int i = 0; i < 3; i++) begin
            if (ew == i) begin
              if ($urandom_range(0, 3) != 0) req[i] = 1'b0;
              rx[i*6 +: 6] = 6'($urandom);
              ry[i*5 +: 5] = 5'($urandom);
            end else if (req[i]) begin
              if ($urandom_range(0, 19) == 0) req[i] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
              req[i] = 1'b1;
              xy = pick_xy();
              rx[i*6 +: 6] = xy[10:5];
              ry[i*5 +: 5] = xy[4:0];
            end
          end
        end
      end
    end

    // Response monitor: every rsp_valid pulse must match the oldest expectation.
    always @(negedge clock) begin
      logic [36:0] e;
      if (rsp_valid != 3'b000) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", k, int'(rsp_valid), 0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_valid", k, int'(rsp_valid), 1 << e[36:35]);
          chk("rsp_data", k, int'(rsp_data), int'(e[34:32]));
          chk("rsp_cycle", k, cyc, int'(e[31:0]));
        end
      end else if (exp_q.size() != 0 && int'(exp_q[0][31:0]) <= cyc) begin
        e = exp_q.pop_front();
        chk("rsp_missing", k, 0, 1 << e[36:35]);
      end
    end
  end

  initial begin
    wait (cyc >= 2700);
    @(negedge clock);
    chk("drain_queue", 0, g_dut[0].exp_q.size(), 0);
    chk("drain_queue", 1, g_dut[1].exp_q.size(), 0);
    chk("reset_phase_done", 0, g_dut[0].ph, 3);
    chk("reset_phase_done", 1, g_dut[1].ph, 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
